bsg_mem_1rw_sync_mask_write_byte_rv: RTL

//  Ready/valid front end for a 1rw synchronous byte-masked SRAM. It drives the

---
 rtl/bsg_mem_1rw_sync_mask_write_byte_rv.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_rv.sv
// rtl/bsg_mem_1rw_sync_mask_write_byte_rv.sv - ready/valid front end for a 1rw byte-masked sync SRAM
// Optional write acknowledgements: define BSG_MEM_1RW_RV_WRITE_ACK_EN.
module bsg_mem_1rw_sync_mask_write_byte_rv #(
  parameter int width_p   = 32,
  parameter int els_p     = 16,
  parameter int buf_els_p = 3,
  localparam int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int write_mask_width_lp = width_p >> 3
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic                           w_i,
  input  logic [addr_width_lp-1:0]       addr_i,
  input  logic [width_p-1:0]             data_i,
  input  logic [write_mask_width_lp-1:0] w_mask_i,
  output logic                           mem_v_o,
  output logic                           mem_w_o,
  output logic [addr_width_lp-1:0]       mem_addr_o,
  output logic [width_p-1:0]             mem_data_o,
  output logic [write_mask_width_lp-1:0] mem_w_mask_o,
  input  logic [width_p-1:0]             mem_data_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           yumi_i
);

  localparam int ptr_w_lp = $clog2(buf_els_p);
  localparam int cnt_w_lp = $clog2(buf_els_p + 1);
  localparam int occ_w_lp = cnt_w_lp + 1;

  logic                rd_inflight_q, rd_inflight_d;
  logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [width_p-1:0]  buf_mem_q [buf_els_p];
  logic [width_p-1:0]  buf_mem_d [buf_els_p];
  logic [occ_w_lp-1:0] occ;
  logic                accept, enq, deq;
  logic [width_p-1:0]  enq_data;

`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
  logic wr_ack_q, wr_ack_d;
`endif

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(buf_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // An in-flight read holds a slot so its data can always be enqueued.
  assign occ         = {1'b0, count_q} + {{cnt_w_lp{1'b0}}, rd_inflight_q};
  assign ready_and_o = ~reset_i & (occ < occ_w_lp'(buf_els_p));
  assign accept      = v_i & ready_and_o;

  assign mem_v_o      = accept;
  assign mem_w_o      = w_i;
  assign mem_addr_o   = addr_i;
  assign mem_data_o   = data_i;
  assign mem_w_mask_o = w_i ? w_mask_i : '0;

  assign v_o    = (count_q != '0);
  assign data_o = buf_mem_q[head_q];
  assign enq    = rd_inflight_q;
  assign deq    = yumi_i & v_o;

`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
  assign enq_data = wr_ack_q ? '0 : mem_data_i;
`else
  assign enq_data = mem_data_i;
`endif

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    buf_mem_d = buf_mem_q;
`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
    rd_inflight_d = accept;
    wr_ack_d      = accept & w_i;
`else
    rd_inflight_d = accept & ~w_i;
`endif
    if (enq) begin
      buf_mem_d[tail_q] = enq_data;
      tail_d            = ptr_inc(tail_q);
    end
    if (deq) begin
      head_d = ptr_inc(head_q);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_inflight_q <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
      wr_ack_q      <= 1'b0;
`endif
    end else begin
      rd_inflight_q <= rd_inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
      wr_ack_q      <= wr_ack_d;
`endif
    end
  end

  // Entry contents are meaningless while the count says empty, so no reset.
  always_ff @(posedge clk_i) begin
    buf_mem_q <= buf_mem_d;
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq && !deq && (count_q == cnt_w_lp'(buf_els_p))));
      assert (!(yumi_i && !v_o));
      assert (!$isunknown(v_i));
      assert (!$isunknown(yumi_i));
    end
  end
`endif

endmodule
